// File: rtl/reflet_periph_arbiter_pkg.sv
// Shared types for the peripheral bus arbiter: FSM state encoding and width helper.
package reflet_periph_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reflet_rr_picker.sv
// Round-robin picker: first asserted req searching upward from ptr+1, wrapping at n_req.
module reflet_rr_picker
  import reflet_periph_arbiter_pkg::*;
#(
  parameter int n_req = 2,
  localparam int IW = clog2_min1(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    idx
);

  logic [n_req-1:0] rotated;
  int first;
  int sum;

  always_comb begin
    // Bit k of rotated is requester (ptr + 1 + k) mod n_req.
    rotated = n_req'({req, req} >> (int'(ptr) + 1));
    first = 0;
    for (int k = n_req - 1; k >= 0; k--) begin
      if (rotated[k]) first = k;
    end
    sum = int'(ptr) + 1 + first;
    if (sum >= n_req) sum = sum - n_req;
    idx = IW'(sum);
  end

  assign any = |req;

endmodule

// File: rtl/reflet_periph_arbiter.sv
// Round-robin arbiter sharing one peripheral register bus between n_req requesters,
// with lock-based owner retention bounded by max_hold.
module reflet_periph_arbiter
  import reflet_periph_arbiter_pkg::*;
#(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 16,
  parameter int n_req          = 2,
  parameter int max_hold       = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [n_req-1:0]                 req,
  input  logic [n_req-1:0]                 lock,
  input  logic [n_req-1:0]                 we,
  input  logic [n_req*base_addr_size-1:0]  addr,
  input  logic [n_req*wordsize-1:0]        wdata,
  output logic [n_req-1:0]                 gnt,
  output logic [n_req-1:0]                 ack,
  output logic [wordsize-1:0]              rdata,
  output logic                             bus_en,
  output logic                             bus_we,
  output logic [base_addr_size-1:0]        bus_addr,
  output logic [wordsize-1:0]              bus_wdata,
  input  logic [wordsize-1:0]              bus_rdata
);

  // state  | meaning
  // IDLE   | arbitrate among pending requests
  // ACCESS | owner drives the peripheral bus for one cycle
  // DONE   | ack pulse to owner, rdata valid

  localparam int IW = clog2_min1(n_req);
  localparam int HW = clog2_min1(max_hold + 1);

  arb_state_e state, state_nxt;
  logic [IW-1:0] owner, owner_nxt, rr_ptr, pick_idx;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic have_owner, pick_any, keep_ok, hold_room;
  logic [n_req-1:0] owner_oh, others;
  logic sel_we;
  logic [base_addr_size-1:0] sel_addr;
  logic [wordsize-1:0] sel_wdata;

  reflet_rr_picker #(.n_req(n_req)) u_picker (
    .req (req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    owner_oh  = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < n_req; i++) begin
      if (owner == IW'(i)) begin
        owner_oh[i] = 1'b1;
        sel_we      = we[i];
        sel_addr    = addr[i*base_addr_size +: base_addr_size];
        sel_wdata   = wdata[i*wordsize +: wordsize];
      end
    end
  end

  assign others    = req & ~owner_oh;
  assign keep_ok   = have_owner && |(owner_oh & req & lock);
  assign hold_room = (max_hold == 0) || (hold_cnt < HW'(max_hold));

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = ACCESS;
          // An exhausted lock still wins when nobody else is waiting.
          if (keep_ok && (hold_room || others == '0)) begin
            if (hold_room && hold_cnt != {HW{1'b1}}) hold_nxt = hold_cnt + 1'b1;
          end else begin
            owner_nxt = pick_idx;
            hold_nxt  = '0;
          end
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= IW'(n_req - 1);
      hold_cnt   <= '0;
      have_owner <= 1'b0;
      rdata      <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      if (state == ACCESS) rdata <= sel_we ? '0 : bus_rdata;
      if (state == DONE) begin
        rr_ptr     <= owner;
        have_owner <= 1'b1;
      end
    end
  end

  always_comb begin
    bus_en    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    gnt       = '0;
    ack       = '0;
    if (state == ACCESS) begin
      bus_en    = 1'b1;
      bus_we    = sel_we;
      bus_addr  = sel_addr;
      bus_wdata = sel_wdata;
    end
    if (state != IDLE) gnt = owner_oh;
    if (state == DONE) ack = owner_oh;
  end

endmodule

// File: tb/tb_reflet_periph_arbiter.sv
// Self-checking bench for reflet_periph_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level arbitration model.
module tb_reflet_periph_arbiter;

  localparam int N    = 2;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXH = 2;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0] gnt, ack;
  logic [DW-1:0] rdata;
  logic bus_en, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  reflet_periph_arbiter #(
    .wordsize(DW), .base_addr_size(AW), .n_req(N), .max_hold(MAXH)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  function automatic logic [15:0] periph_val(input logic [15:0] a);
    return (a == 16'hFF00) ? 16'h0001 : (a ^ 16'hA5C3);
  endfunction

  assign bus_rdata = (bus_en && !bus_we) ? periph_val(bus_addr) : 16'h0000;

  int commit_cnt = 0;
  logic [15:0] last_waddr = '0, last_wdata = '0;
  always @(posedge clk) begin
    if (bus_en && bus_we) begin
      commit_cnt <= commit_cnt + 1;
      last_waddr <= bus_addr;
      last_wdata <= bus_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0, a1, d0, d1;
    logic [1:0]  gnt, ack;
    logic        en, bwe;
    logic [15:0] baddr, bwd;
    logic        rd_chk;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[16];

  // Transaction-level reference model state
  int m_phase, m_owner, m_last, m_streak, m_rr;
  logic [15:0] m_rdata;
  bit active[N];

  task automatic model_pick(output int who);
    int others_cnt;
    others_cnt = 0;
    for (int j = 0; j < N; j++) if (j != m_last && req[j]) others_cnt++;
    if (m_last >= 0 && req[m_last] && lock[m_last] && (m_streak < MAXH || others_cnt == 0)) begin
      if (m_streak < MAXH) m_streak++;
      who = m_last;
    end else begin
      m_streak = 0;
      who = 0;
      for (int s = N; s >= 1; s--) if (req[(m_rr + s) % N]) who = (m_rr + s) % N;
    end
  endtask

  initial begin
    int order[$];
    int pos[$];
    int base, got_ack, n_ack;
    logic [1:0] oh;

    reset = 1'b0;
    do_reset();

    // reset state
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_bus_addr", bus_addr, 0);

    //          req    we     a0        a1        d0        d1        gnt    ack    en bwe baddr     bwd       rdc rd
    tbl[0]  = '{2'b01, 2'b00, 16'hFF00, 16'h0000, 16'h1234, 16'h0000, 2'b01, 2'b00, 1, 0, 16'hFF00, 16'h1234, 0, 16'h0000};
    tbl[1]  = '{2'b01, 2'b00, 16'hFF00, 16'h0000, 16'h1234, 16'h0000, 2'b01, 2'b01, 0, 0, 16'h0000, 16'h0000, 1, 16'h0001};
    tbl[2]  = '{2'b00, 2'b00, 16'hFF00, 16'h0000, 16'h1234, 16'h0000, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    tbl[3]  = '{2'b00, 2'b00, 16'hFF00, 16'h0000, 16'h1234, 16'h0000, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    tbl[4]  = '{2'b01, 2'b01, 16'hFF10, 16'h0000, 16'hBEEF, 16'h0000, 2'b01, 2'b00, 1, 1, 16'hFF10, 16'hBEEF, 0, 16'h0000};
    tbl[5]  = '{2'b01, 2'b01, 16'hFF10, 16'h0000, 16'hBEEF, 16'h0000, 2'b01, 2'b01, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000};
    tbl[6]  = '{2'b00, 2'b00, 16'hFF10, 16'h0000, 16'hBEEF, 16'h0000, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    tbl[7]  = '{2'b10, 2'b00, 16'h0000, 16'h0042, 16'h0000, 16'h5555, 2'b10, 2'b00, 1, 0, 16'h0042, 16'h5555, 0, 16'h0000};
    tbl[8]  = '{2'b10, 2'b00, 16'h0000, 16'h0042, 16'h0000, 16'h5555, 2'b10, 2'b10, 0, 0, 16'h0000, 16'h0000, 1, 16'hA581};
    tbl[9]  = '{2'b00, 2'b00, 16'h0000, 16'h0042, 16'h0000, 16'h5555, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    tbl[10] = '{2'b01, 2'b00, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 2'b01, 2'b00, 1, 0, 16'h0007, 16'h0000, 0, 16'h0000};
    tbl[11] = '{2'b01, 2'b00, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 2'b01, 2'b01, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5C4};
    tbl[12] = '{2'b01, 2'b00, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    tbl[13] = '{2'b01, 2'b00, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 2'b01, 2'b00, 1, 0, 16'h0007, 16'h0000, 0, 16'h0000};
    tbl[14] = '{2'b00, 2'b00, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 2'b01, 2'b01, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5C4};
    tbl[15] = '{2'b00, 2'b00, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};

    base = commit_cnt;
    for (int k = 0; k < 16; k++) begin
      req = tbl[k].req; we = tbl[k].we; lock = '0;
      addr = {tbl[k].a1, tbl[k].a0};
      wdata = {tbl[k].d1, tbl[k].d0};
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", k), gnt, tbl[k].gnt);
      chk($sformatf("tbl%0d_ack", k), ack, tbl[k].ack);
      chk($sformatf("tbl%0d_bus_en", k), bus_en, tbl[k].en);
      chk($sformatf("tbl%0d_bus_we", k), bus_we, tbl[k].bwe);
      chk($sformatf("tbl%0d_bus_addr", k), bus_addr, tbl[k].baddr);
      chk($sformatf("tbl%0d_bus_wdata", k), bus_wdata, tbl[k].bwd);
      if (tbl[k].rd_chk) chk($sformatf("tbl%0d_rdata", k), rdata, tbl[k].rd);
    end
    chk("tbl_commits", commit_cnt - base, 1);
    chk("tbl_commit_addr", last_waddr, 16'hFF10);
    chk("tbl_commit_data", last_wdata, 16'hBEEF);

    // contention from reset: alternating owners, one ack per requester every 6 cycles
    do_reset();
    addr = {16'h0200, 16'h0100}; req = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        order.push_back(ack == 2'b10 ? 1 : 0);
        pos.push_back(c);
        chk("cont_rdata", rdata, (ack == 2'b10) ? 16'hA7C3 : 16'hA4C3);
      end
    end
    chk("cont_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) begin
      chk($sformatf("cont_owner%0d", i), order[i], i % 2);
      chk($sformatf("cont_pos%0d", i), pos[i], 2 + 3 * i);
    end

    // lock fairness: initial grant + MAXH locked grants, then forced rotation
    do_reset();
    order.delete();
    addr = {16'h0400, 16'h0300}; req = 2'b11; lock = 2'b01;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (ack != 0) order.push_back(ack == 2'b10 ? 1 : 0);
    end
    chk("lock_count", order.size(), 8);
    for (int i = 0; i < order.size() && i < 8; i++)
      chk($sformatf("lock_owner%0d", i), order[i], (i % 4 == 3) ? 1 : 0);
    req = 2'b01;
    n_ack = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        n_ack++;
        chk("lock_solo_ack", ack, 2'b01);
      end
    end
    chk("lock_solo_count", n_ack, 5);

    // reset asserted during the ACCESS cycle of a write
    do_reset();
    req = 2'b01; we = 2'b01; addr = {16'h0500, 16'hFF20}; wdata = {16'h0000, 16'hCAFE};
    @(negedge clk);
    chk("rma_bus_en_before", bus_en, 1);
    chk("rma_bus_we_before", bus_we, 1);
    base = commit_cnt;
    #2 reset = 1'b0;
    #1;
    chk("rma_bus_en_async", bus_en, 0);
    chk("rma_gnt", gnt, 0);
    chk("rma_ack", ack, 0);
    req = 2'b11; we = 2'b00;
    @(negedge clk);
    chk("rma_no_commit", commit_cnt - base, 0);
    reset = 1'b1;
    got_ack = 0;
    for (int c = 0; c < 10 && got_ack == 0; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        got_ack = 1;
        chk("rma_first_owner", ack, 2'b01);
        chk("rma_first_rdata", rdata, 16'h5AE3);
      end
    end
    if (got_ack == 0) chk("rma_ack_timeout", 0, 1);
    chk("rma_no_commit_after", commit_cnt - base, 0);

    // req1 dropped during its ACCESS: still acked exactly once
    do_reset();
    req = 2'b10; addr = {16'h0600, 16'h0000};
    @(negedge clk);
    chk("viol_gnt", gnt, 2'b10);
    chk("viol_bus_en", bus_en, 1);
    req = 2'b00;
    @(negedge clk);
    chk("viol_ack", ack, 2'b10);
    chk("viol_rdata", rdata, 16'hA3C3);
    @(negedge clk);
    chk("viol_ack_gone", ack, 0);
    chk("viol_gnt_gone", gnt, 0);
    @(negedge clk);
    chk("viol_idle", bus_en, 0);

    // randomized traffic against the reference model
    do_reset();
    m_phase = 0; m_owner = 0; m_last = -1; m_streak = 0; m_rr = N - 1; m_rdata = '0;
    for (int i = 0; i < N; i++) active[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (m_phase == 2 && m_owner == i) active[i] = 0;
        if (!active[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            active[i] = 1;
            req[i] = 1'b1;
            we[i] = 1'($urandom_range(0, 1));
            addr[i*AW +: AW] = 16'($urandom);
            wdata[i*DW +: DW] = 16'($urandom);
            lock[i] = ($urandom_range(0, 9) < 6);
          end else begin
            req[i] = 1'b0;
            lock[i] = 1'($urandom_range(0, 1));
          end
        end
      end
      case (m_phase)
        0: if (req != 0) begin model_pick(m_owner); m_phase = 1; end
        1: begin
          m_rdata = we[m_owner] ? 16'h0000 : periph_val(addr[m_owner*AW +: AW]);
          m_phase = 2;
        end
        default: begin m_last = m_owner; m_rr = m_owner; m_phase = 0; end
      endcase
      @(negedge clk);
      oh = 2'b01 << m_owner;
      chk("rnd_gnt", gnt, (m_phase != 0) ? oh : 2'b00);
      chk("rnd_ack", ack, (m_phase == 2) ? oh : 2'b00);
      chk("rnd_bus_en", bus_en, m_phase == 1);
      chk("rnd_bus_we", bus_we, (m_phase == 1) ? we[m_owner] : 1'b0);
      chk("rnd_bus_addr", bus_addr, (m_phase == 1) ? addr[m_owner*AW +: AW] : 16'h0000);
      chk("rnd_bus_wdata", bus_wdata, (m_phase == 1) ? wdata[m_owner*DW +: DW] : 16'h0000);
      if (m_phase == 2) chk("rnd_rdata", rdata, m_rdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
